ipv4_checksum_verify: RTL and testbench

Receive-side IPv4 header checksum checker. Consumes a packet as a stream of 16-bit big-endian words and runs a one's-complement accumulation over the IHL-defined header. Reports once per packet whether the header checksum is correct, and reports the checksum the header should carry. It sits in the ingress path, after deframing and before any forwarding logic that rewrites header fields and patches the checksum incrementally.

---
 rtl/ipv4_checksum_verify.sv | 127 ++++++++++++
 tb/tb_ipv4_checksum_verify.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_checksum_verify.sv
// ipv4_checksum_verify
//   Receive-side IPv4 header checksum checker. Packets arrive as 16-bit
//   big-endian words. Once per packet the block reports whether the header
//   checksum is correct, the checksum the header should carry, and the
//   one's-complement sum of the whole header.
//
// Ports
//   clk               rising-edge clock
//   sreset            synchronous active-high reset
//   in_valid          qualifies in_sop / in_last / in_data (no backpressure)
//   in_sop            first word of a packet
//   in_last           final word of a packet
//   in_data[15:0]     packet word, byte 0 in [15:8]
//   result_valid      single-cycle pulse, result fields valid
//   checksum_ok       header sum equals 16'hFFFF
//   header_error      bad version, IHL < 5, truncated or abandoned header
//   expected_checksum ~(sum of header words excluding word 5)
//   header_sum        one's-complement sum of all header words
module ipv4_checksum_verify (
  input  logic        clk,
  input  logic        sreset,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_last,
  input  logic [15:0] in_data,
  output logic        result_valid,
  output logic        checksum_ok,
  output logic        header_error,
  output logic [15:0] expected_checksum,
  output logic [15:0] header_sum
);

  typedef enum logic [1:0] {IDLE, HEADER, SKIP} state_t;

  state_t      state;
  logic [3:0]  ihl;
  logic [4:0]  word_cnt;
  logic [15:0] sum_all;
  logic [15:0] sum_nock;

  logic [15:0] add_all;
  logic [15:0] add_nock;
  logic        hdr_done;
  logic        sop_bad;

  // End-around-carry addition; a single fold suffices since
  // FFFF + FFFF = 1FFFE folds to FFFF without a second carry.
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  always_comb begin
    add_all  = oc_add(sum_all, in_data);
    add_nock = (word_cnt == 5'd5) ? sum_nock : oc_add(sum_nock, in_data);
    hdr_done = (word_cnt == ({ihl, 1'b0} - 5'd1));
    sop_bad  = (in_data[15:12] != 4'd4) || (in_data[11:8] < 4'd5);
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state             <= IDLE;
      ihl               <= '0;
      word_cnt          <= '0;
      sum_all           <= '0;
      sum_nock          <= '0;
      result_valid      <= 1'b0;
      checksum_ok       <= 1'b0;
      header_error      <= 1'b0;
      expected_checksum <= '0;
      header_sum        <= '0;
    end else begin
      result_valid <= 1'b0;
      if (in_valid) begin
        if (in_sop) begin
          // Abandon result first; a result from the new SOP word below
          // overrides it, so only one pulse is produced per cycle.
          if (state == HEADER) begin
            result_valid <= 1'b1;
            header_error <= 1'b1;
            checksum_ok  <= 1'b0;
          end
          ihl      <= in_data[11:8];
          word_cnt <= 5'd1;
          sum_all  <= in_data;
          sum_nock <= in_data;
          if (in_last || sop_bad) begin
            result_valid <= 1'b1;
            header_error <= 1'b1;
            checksum_ok  <= 1'b0;
            state        <= in_last ? IDLE : SKIP;
          end else begin
            state <= HEADER;
          end
        end else begin
          case (state)
            HEADER: begin
              sum_all  <= add_all;
              sum_nock <= add_nock;
              word_cnt <= word_cnt + 5'd1;
              if (hdr_done) begin
                result_valid      <= 1'b1;
                header_error      <= 1'b0;
                checksum_ok       <= (add_all == 16'hFFFF);
                expected_checksum <= ~add_nock;
                header_sum        <= add_all;
                state             <= in_last ? IDLE : SKIP;
              end else if (in_last) begin
                result_valid <= 1'b1;
                header_error <= 1'b1;
                checksum_ok  <= 1'b0;
                state        <= IDLE;
              end
            end
            SKIP: begin
              if (in_last) state <= IDLE;
            end
            IDLE: ;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ipv4_checksum_verify.sv
module tb_ipv4_checksum_verify;

  logic        clk = 1'b0;
  logic        sreset;
  logic        in_valid, in_sop, in_last;
  logic [15:0] in_data;
  logic        result_valid, checksum_ok, header_error;
  logic [15:0] expected_checksum, header_sum;

  ipv4_checksum_verify dut (
    .clk              (clk),
    .sreset           (sreset),
    .in_valid         (in_valid),
    .in_sop           (in_sop),
    .in_last          (in_last),
    .in_data          (in_data),
    .result_valid     (result_valid),
    .checksum_ok      (checksum_ok),
    .header_error     (header_error),
    .expected_checksum(expected_checksum),
    .header_sum       (header_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, sop, last;
    logic [15:0] d;
    bit          rv, err, ok;
    logic [15:0] ec, hs;
  } cyc_t;

  cyc_t        stream[$];
  bit          pending = 0;   // a packet is open mid-header with no in_last
  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [15:0] fold(input int unsigned s);
    int unsigned t;
    t = s;
    while (t > 32'hFFFF) t = (t & 32'hFFFF) + (t >> 16);
    return t[15:0];
  endfunction

  task automatic push_cyc(input logic v, input logic sop, input logic last, input logic [15:0] d);
    cyc_t c;
    c.v = v; c.sop = sop; c.last = last; c.d = d;
    c.rv = 0; c.err = 0; c.ok = 0; c.ec = '0; c.hs = '0;
    stream.push_back(c);
  endtask

  // Packet-level reference: decides from the header rules where the single
  // result lands in the cycle stream and what it carries.
  task automatic add_pkt(input logic [15:0] w[$], input bit term);
    int          base, n, hlen, res_at;
    bit          res_err;
    logic [15:0] ec, hs;
    logic [15:0] w0;
    logic [3:0]  ver, ihl;
    int unsigned sa, sn;
    base = stream.size(); n = w.size(); res_at = -1; res_err = 0;
    ec = '0; hs = '0; sa = 0; sn = 0;
    w0 = w[0]; ver = w0[15:12]; ihl = w0[11:8]; hlen = 2 * int'(ihl);
    for (int i = 0; i < n; i++) push_cyc(1'b1, i == 0, term && (i == n - 1), w[i]);
    if (ver != 4'd4 || ihl < 4'd5) begin
      res_at = base; res_err = 1;
    end else if (n < hlen) begin
      if (term) begin res_at = base + n - 1; res_err = 1; end
    end else begin
      for (int i = 0; i < hlen; i++) begin
        sa += w[i];
        if (i != 5) sn += w[i];
      end
      res_at = base + hlen - 1; hs = fold(sa); ec = ~fold(sn);
    end
    if (pending && res_at != base) begin
      stream[base].rv = 1; stream[base].err = 1; stream[base].ok = 0;
    end
    if (res_at >= 0) begin
      stream[res_at].rv  = 1;
      stream[res_at].err = res_err;
      stream[res_at].ok  = !res_err && (hs == 16'hFFFF);
      stream[res_at].ec  = ec;
      stream[res_at].hs  = hs;
    end
    pending = (ver == 4'd4) && (ihl >= 4'd5) && (n < hlen) && !term;
  endtask

  task automatic add_gap(input int n);
    for (int i = 0; i < n; i++)
      push_cyc(!pending && $urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 1) == 1, 16'($urandom));
  endtask

  // kind 0: correct checksum, 1: corrupted checksum, 2: bad version/IHL
  task automatic gen_pkt(output logic [15:0] q[$], input int kind);
    logic [3:0]  ihl, ver;
    int unsigned s;
    q.delete();
    ihl = 4'($urandom_range(5, 8));
    q.push_back({4'd4, ihl, 8'($urandom)});
    for (int i = 1; i < 2 * int'(ihl); i++) q.push_back(16'($urandom));
    s = 0;
    q[5] = '0;
    foreach (q[i]) s += q[i];
    q[5] = ~fold(s);
    if (kind == 1) q[5] = q[5] ^ (16'd1 << $urandom_range(0, 15));
    if (kind == 2) begin
      if ($urandom_range(0, 1) == 1) begin
        ver = 4'($urandom_range(5, 15));
        q[0] = {ver, q[0][11:0]};
      end else begin
        ihl = 4'($urandom_range(0, 4));
        q[0] = {4'd4, ihl, q[0][7:0]};
      end
    end
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) q.push_back(16'($urandom));
  endtask

  task automatic run_stream(input string name);
    foreach (stream[i]) begin
      in_valid = stream[i].v; in_sop = stream[i].sop;
      in_last = stream[i].last; in_data = stream[i].d;
      @(posedge clk); #1;
      chk($sformatf("%s.rv[%0d]", name, i), 16'(result_valid), 16'(stream[i].rv));
      if (stream[i].rv) begin
        chk($sformatf("%s.err[%0d]", name, i), 16'(header_error), 16'(stream[i].err));
        chk($sformatf("%s.ok[%0d]", name, i), 16'(checksum_ok), 16'(stream[i].ok));
        if (!stream[i].err) begin
          chk($sformatf("%s.ec[%0d]", name, i), expected_checksum, stream[i].ec);
          chk($sformatf("%s.hs[%0d]", name, i), header_sum, stream[i].hs);
        end
      end
    end
    in_valid = 0; in_sop = 0; in_last = 0; in_data = '0;
    stream.delete();
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".rv"}, 16'(result_valid), 16'd0);
    chk({name, ".ok"}, 16'(checksum_ok), 16'd0);
    chk({name, ".err"}, 16'(header_error), 16'd0);
    chk({name, ".ec"}, expected_checksum, 16'h0000);
    chk({name, ".hs"}, header_sum, 16'h0000);
  endtask

  initial begin
    logic [15:0] g[$];
    logic [15:0] q[$];
    int unsigned s;

    sreset = 1; in_valid = 0; in_sop = 0; in_last = 0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    sreset = 0;

    // Reference header with correct checksum B861, then 4 payload words.
    g = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
          16'hB861, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};
    q = g; q.push_back(16'h1111); q.push_back(16'h2222); q.push_back(16'h3333); q.push_back(16'h4444);
    add_pkt(q, 1);
    add_gap(2);
    run_stream("golden");
    chk("golden.hold_hs", header_sum, 16'hFFFF);
    chk("golden.hold_ec", expected_checksum, 16'hB861);

    q = g; q[5] = 16'hB862; q.push_back(16'h0);
    add_pkt(q, 1);
    run_stream("corrupt");

    // IHL 6 with an options word pair; checksum recomputed for the new header.
    q = g; q[0] = 16'h4600; q.push_back(16'h0000); q.push_back(16'h0000);
    s = 0; q[5] = '0;
    foreach (q[i]) s += q[i];
    q[5] = ~fold(s);
    q.push_back(16'hABCD);
    add_pkt(q, 1);
    run_stream("ihl6");

    q = '{16'h6500, 16'h0001, 16'h0002};
    add_pkt(q, 1);
    q = '{16'h4400, 16'h0001, 16'h0002, 16'h0003};
    add_pkt(q, 1);
    q = g; q = q[0:6];
    add_pkt(q, 1);
    q = '{16'h4500};
    add_pkt(q, 1);
    run_stream("malformed");

    // Back-to-back: B's SOP immediately after A's in_last.
    q = g; q.push_back(16'h5555);
    add_pkt(q, 1);
    q = g; q[5] = 16'h1234;
    add_pkt(q, 1);
    run_stream("b2b");

    // SOP mid-header abandons A, B is valid.
    q = g; q = q[0:3];
    add_pkt(q, 0);
    q = g;
    add_pkt(q, 1);
    run_stream("abort");

    // Reset in the middle of a header: no result and outputs cleared.
    q = g; q = q[0:2];
    foreach (q[i]) push_cyc(1'b1, i == 0, 1'b0, q[i]);
    run_stream("prerst");
    sreset = 1;
    @(posedge clk); #1;
    chk_zero("midrst");
    sreset = 0;
    pending = 0;
    q = g; q.push_back(16'h7777);
    add_pkt(q, 1);
    run_stream("postrst");

    // Randomized traffic: mixed kinds, truncations, gaps and aborts.
    for (int p = 0; p < 60; p++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      gen_pkt(q, kind);
      if ($urandom_range(0, 5) == 0) begin
        int cut;
        cut = int'($urandom_range(1, q.size()));
        q = q[0:cut-1];
        add_pkt(q, $urandom_range(0, 1) == 1);
      end else begin
        add_pkt(q, 1);
      end
      add_gap(int'($urandom_range(0, 2)));
    end
    q = g;
    add_pkt(q, 1);
    add_gap(2);
    run_stream("rand");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
